// File: rtl/alu_decode_if.sv
// alu_decode_if: fetch-side, execute-side and counter signals of the decode stage.
// With ILLEGAL_CHECK_EN defined, it also carries the illegal and illegal_seen flags.
interface alu_decode_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_ctrl;
  logic             alu_src_imm;
  logic [XLEN-1:0]  imm;
  logic [4:0]       rs1, rs2, rd;
  logic             reg_write, mem_read, mem_write, branch, jump;
  logic [CNT_W-1:0] issued_cnt;
`ifdef ILLEGAL_CHECK_EN
  logic             illegal, illegal_seen;
`endif
  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, alu_ctrl, alu_src_imm, imm, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch, jump, issued_cnt
`ifdef ILLEGAL_CHECK_EN
    , output illegal, illegal_seen
`endif
  );
  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, alu_ctrl, alu_src_imm, imm, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch, jump, issued_cnt
`ifdef ILLEGAL_CHECK_EN
    , input illegal, illegal_seen
`endif
  );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode stage with one registered output slot and an issued-bundle counter.
// Defining ILLEGAL_CHECK_EN adds illegal-encoding detection and a sticky illegal_seen flag.
module alu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_decode_if.slave  bus
);
  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic            alu_src_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1, rs2, rd;
    logic            reg_write, mem_read, mem_write, branch, jump;
  } bundle_t;
  bundle_t dec, bundle_d, bundle_q;
  logic out_valid_q, out_valid_d, accept, fire;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [31:0] ins;
  logic [6:0] op;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign ins   = bus.in_instr;
  assign op    = ins[6:0];
  assign f3    = ins[14:12];
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  always_comb begin
    dec     = '0;
    dec.rs1 = ins[19:15];
    dec.rs2 = ins[24:20];
    dec.rd  = ins[11:7];
    case (op)
      7'b0110011: begin
        dec.alu_ctrl  = {ins[30], f3};
        dec.reg_write = 1'b1;
      end
      7'b0010011: begin
        dec.alu_ctrl    = {f3 == 3'b101 && ins[30], f3};
        dec.imm         = f3[1:0] == 2'b01 ? XLEN'(ins[24:20]) : imm_i;
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      7'b0110111: begin
        dec.alu_ctrl    = 4'b1001;
        dec.imm         = imm_u;
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      7'b0010111: begin
        dec.imm         = imm_u;
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      7'b0000011: begin
        dec.imm       = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      7'b0100011: begin
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
      end
      7'b1100011: begin
        dec.alu_ctrl = !f3[2] ? 4'b1000 : f3[1] ? 4'b0011 : 4'b0010;
        dec.imm      = imm_b;
        dec.branch   = 1'b1;
      end
      7'b1101111: begin
        dec.imm       = imm_j;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      7'b1100111: begin
        dec.imm         = imm_i;
        dec.alu_src_imm = 1'b1;
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
      end
      default: dec.alu_ctrl = 4'b0000;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end
`ifdef ILLEGAL_CHECK_EN
  logic ill_d, illegal_q, illegal_seen_q;
  logic [6:0] f7;
  assign f7 = ins[31:25];
  always_comb begin
    ill_d = 1'b0;
    case (op)
      7'b0110011: ill_d = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      7'b0010011: ill_d = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      7'b1100011: ill_d = f3[2:1] == 2'b01;
      7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111: ill_d = 1'b0;
      default: ill_d = 1'b1;
    endcase
  end
  always_comb begin
    bundle_d = dec;
    if (ill_d) {bundle_d.alu_src_imm, bundle_d.reg_write, bundle_d.mem_read, bundle_d.mem_write, bundle_d.branch, bundle_d.jump} = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      illegal_q      <= 1'b0;
      illegal_seen_q <= 1'b0;
    end else if (accept) begin
      illegal_q      <= ill_d;
      illegal_seen_q <= illegal_seen_q | ill_d;
    end
  assign bus.illegal      = illegal_q;
  assign bus.illegal_seen = illegal_seen_q;
`else
  assign bundle_d = dec;
`endif
  // A flush both empties the slot and blocks the incoming word in the same edge.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign fire         = out_valid_q && bus.out_ready;
  assign out_valid_d  = bus.flush ? 1'b0 : accept ? 1'b1 : fire ? 1'b0 : out_valid_q;
  assign issued_cnt_d = issued_cnt_q + CNT_W'(fire);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      issued_cnt_q <= '0;
      bundle_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      issued_cnt_q <= issued_cnt_d;
      if (accept) bundle_q <= bundle_d;
    end
  assign bus.out_valid   = out_valid_q;
  assign bus.issued_cnt  = issued_cnt_q;
  assign bus.alu_ctrl    = bundle_q.alu_ctrl;
  assign bus.alu_src_imm = bundle_q.alu_src_imm;
  assign bus.imm         = bundle_q.imm;
  assign bus.rs1         = bundle_q.rs1;
  assign bus.rs2         = bundle_q.rs2;
  assign bus.rd          = bundle_q.rd;
  assign bus.reg_write   = bundle_q.reg_write;
  assign bus.mem_read    = bundle_q.mem_read;
  assign bus.mem_write   = bundle_q.mem_write;
  assign bus.branch      = bundle_q.branch;
  assign bus.jump        = bundle_q.jump;
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed vectors into a scoreboard queue; a negedge monitor pops and
// compares every bundle the execute side accepts.
module tb_alu_decode_stage;
  logic clk = 1'b0;
  logic rst_n;
  int nvec = 0;
  int nerr = 0;
  int w;
  logic [56:0] exp_q[$];
  logic [56:0] act, dump;
  alu_decode_if #(.XLEN(32), .CNT_W(32)) bus();
  alu_decode_stage #(.XLEN(32), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign act = {bus.alu_ctrl, bus.alu_src_imm, bus.imm, bus.rs1, bus.rs2, bus.rd,
                bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump};
  function automatic logic [56:0] mk(logic [3:0] alu, logic src, logic [31:0] imm, logic [4:0] rs1,
                                     logic [4:0] rs2, logic [4:0] rd, logic rw, logic mr, logic mw,
                                     logic br, logic jp);
    return {alu, src, imm, rs1, rs2, rd, rw, mr, mw, br, jp};
  endfunction
  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, a, e);
    end
  endtask
  task automatic send(logic [31:0] ins, logic [56:0] e, output int waits);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: instr %h not accepted, required acceptance within 20 cycles", ins);
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      #1;
    end
  endtask
  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.out_valid && bus.out_ready) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_bundle: got %h, required no bundle", act);
      end else begin
        logic [56:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          nerr++;
          $display("FAIL bundle: got %h, required %h", act, e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_issued", 64'(bus.issued_cnt), 64'd0);
    chk("reset_bundle", 64'(act), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h002081B3, mk(4'b0000, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0), w);
    send(32'h402081B3, mk(4'b1000, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0), w);
    chk("back_to_back_waits", 64'(w), 64'd0);
    idle(2);
    chk("issued_after_add_sub", 64'(bus.issued_cnt), 64'd2);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    send(32'h40435293, mk(4'b1101, 1, 32'h4,        6,  4,  5, 1, 0, 0, 0, 0), w);
    send(32'hC0000093, mk(4'b0000, 1, 32'hFFFFFC00, 0,  0,  1, 1, 0, 0, 0, 0), w);
    send(32'h123450B7, mk(4'b1001, 1, 32'h12345000, 8,  3,  1, 1, 0, 0, 0, 0), w);
    send(32'h00512423, mk(4'b0000, 0, 32'h8,        2,  5,  8, 0, 0, 1, 0, 0), w);
    send(32'hFFC1A383, mk(4'b0000, 0, 32'hFFFFFFFC, 3, 28,  7, 1, 1, 0, 0, 0), w);
    send(32'hFFC1A003, mk(4'b0000, 0, 32'hFFFFFFFC, 3, 28,  0, 0, 1, 0, 0, 0), w);
    send(32'h0020E863, mk(4'b0011, 0, 32'h10,       1,  2, 16, 0, 0, 0, 1, 0), w);
    send(32'hFE000EE3, mk(4'b1000, 0, 32'hFFFFFFFC, 0,  0, 29, 0, 0, 0, 1, 0), w);
    send(32'h008000EF, mk(4'b0000, 0, 32'h8,        0,  8,  1, 1, 0, 0, 0, 1), w);
    send(32'h00008067, mk(4'b0000, 1, 32'h0,        1,  0,  0, 0, 0, 0, 0, 1), w);
    send(32'hFFFFF517, mk(4'b0000, 1, 32'hFFFFF000, 31, 31, 10, 1, 0, 0, 0, 0), w);
    send(32'h0000007F, mk(4'b0000, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0), w);
    idle(2);
    chk("issued_after_vectors", 64'(bus.issued_cnt), 64'd14);
    bus.out_ready = 1'b0;
    send(32'h002081B3, mk(4'b0000, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0), w);
    bus.in_instr = 32'h402081B3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_hold", 64'({bus.out_valid, act}), 64'({1'b1, mk(4'b0000, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0)}));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h402081B3, mk(4'b1000, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0), w);
    chk("release_waits", 64'(w), 64'd0);
    idle(2);
    chk("issued_after_stall", 64'(bus.issued_cnt), 64'd16);
    bus.out_ready = 1'b0;
    send(32'h40435293, mk(4'b1101, 1, 32'h4, 6, 4, 5, 1, 0, 0, 0, 0), w);
    bus.in_instr = 32'h123450B7;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    dump = exp_q.pop_back();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    idle(3);
    chk("flush_dropped_input", 64'(bus.out_valid), 64'd0);
    chk("flush_issued", 64'(bus.issued_cnt), 64'd16);
    bus.out_ready = 1'b0;
    send(32'hC0000093, mk(4'b0000, 1, 32'hFFFFFC00, 0, 0, 1, 1, 0, 0, 0, 0), w);
    bus.out_ready = 1'b1;
    bus.in_instr = 32'h123450B7;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_drain_out_valid", 64'(bus.out_valid), 64'd0);
    idle(2);
    chk("flush_drain_issued", 64'(bus.issued_cnt), 64'd17);
    bus.out_ready = 1'b0;
    send(32'h123450B7, mk(4'b1001, 1, 32'h12345000, 8, 3, 1, 1, 0, 0, 0, 0), w);
    dump = exp_q.pop_back();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_reset_issued", 64'(bus.issued_cnt), 64'd0);
    chk("async_reset_bundle", 64'(act), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
`ifdef ILLEGAL_CHECK_EN
    chk("illegal_seen_clear", 64'(bus.illegal_seen), 64'd0);
    bus.out_ready = 1'b1;
    send(32'h0000007F, mk(4'b0000, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0), w);
    chk("illegal_flag", 64'(bus.illegal), 64'd1);
    idle(2);
    chk("illegal_seen_sticky", 64'(bus.illegal_seen), 64'd1);
`endif
    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode pipeline stage between fetch and execute. Accepts one RV32I instruction word per handshake and decodes it into ALU control, immediate and register-file/memory control signals.
- Results are held in a single registered output slot. This stage is the producer of the 4-bit ALU control code consumed by the execute ALU.
- Valid/ready on both sides; flush input for branch redirect.

Parameters:
- XLEN, 32, datapath and immediate width.
- CNT_W, 32, width of issued-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discard held and incoming instruction.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  stage can accept.
- in_instr  input  32  instruction word.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute stage accepts.
- alu_ctrl  output  4  ALU operation code.
- alu_src_imm  output  1  ALU operand 2 = imm (else rs2 data).
- imm  output  XLEN  sign-extended immediate.
- rs1, rs2, rd  output  5 each  register indices.
- reg_write, mem_read, mem_write, branch, jump  output  1 each  control flags.
- issued_cnt  output  CNT_W  count of bundles accepted by execute.

Behaviour:
- Reset (rst_n low, async): out_valid=0, issued_cnt=0, all bundle fields 0. in_ready=1 once reset is released.
- in_ready = !out_valid || out_ready (combinational). No skid buffer.
- Accept when in_valid && in_ready. The decoded bundle is registered on that edge; out_valid=1 the next cycle. Latency is 1 cycle.
- While out_valid && !out_ready: the bundle holds stable and in_ready=0.
- Simultaneous drain and accept (out_ready=1, in_valid=1): the new bundle replaces the old one in the same edge. Throughput is 1 per cycle.
- out_valid && out_ready with no new input: out_valid goes to 0.
- flush: has priority over everything. The next edge sets out_valid=0, and any concurrent input is dropped. issued_cnt still increments if out_valid && out_ready in the flush cycle.
- issued_cnt increments by 1 on each out_valid && out_ready and wraps at 2^CNT_W.
- ALU codes: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111, pass-op2 1001.
- Opcode 0110011 (R-type): alu_ctrl={instr[30],funct3}; reg_write=1.
- Opcode 0010011 (I-ALU): alu_ctrl={funct3==101 ? instr[30] : 0, funct3}; alu_src_imm=1; reg_write=1. For addi, instr[30] is imm and never produces sub.
- Opcode 0110111 (LUI): 1001, imm={instr[31:12],12'b0}, alu_src_imm=1, reg_write=1.
- Opcode 0010111 (AUIPC): 0000, U-imm, alu_src_imm=1, reg_write=1.
- Opcode 0000011 (load): 0000, I-imm, mem_read=1, reg_write=1.
- Opcode 0100011 (store): 0000, S-imm, mem_write=1.
- Opcode 1100011 (branch): B-imm, branch=1. funct3 00x -> 1000; 10x -> 0010; 11x -> 0011.
- Opcode 1101111 (JAL): 0000, J-imm, jump=1, reg_write=1.
- Opcode 1100111 (JALR): 0000, I-imm, alu_src_imm=1, jump=1, reg_write=1.
- Any other opcode: NOP bundle (alu_ctrl 0000, all control flags 0).
- rd=0 forces reg_write=0.
- rs1/rs2/rd are taken from fixed fields for all formats.

Optional Feature:
- ILLEGAL_CHECK_EN defined: adds outputs illegal (1 bit, part of the bundle) and illegal_seen (sticky, cleared only by reset).
  - illegal=1 for an unknown opcode.
  - illegal=1 for R-type with funct7 not 0000000, or 0100000 outside funct3 000/101.
  - illegal=1 for shift-immediates with bad funct7.
  - illegal=1 for branch funct3 01x.
  - Illegal bundles carry all control flags 0.
  - illegal_seen sets on acceptance of an illegal instruction.
- Undefined: ports absent; such encodings decode per the table or as NOP.

Test Plan:
- Reset mid-bundle (out_valid=1, out_ready=0), pulse rst_n low -> out_valid=0 and issued_cnt=0 immediately (async), in_ready=1 after release.
- 0x002081B3 (add x3,x1,x2) then 0x402081B3 (sub), out_ready=1 -> alu_ctrl 0000 then 1000, rs1=1, rs2=2, rd=3, reg_write=1; back-to-back, one per cycle; issued_cnt=2.
- 0x40435293 (srai x5,x6,4) -> alu_ctrl 1101, imm=4, alu_src_imm=1. 0xC0000093 (addi x1,x0,-1024) -> alu_ctrl 0000, imm=0xFFFFFC00.
- 0x123450B7 (lui x1,0x12345) -> alu_ctrl 1001, imm=0x12345000, reg_write=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and bundle stable. Release -> next instruction accepted on the same edge.
- flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input dropped. ILLEGAL_CHECK_EN: opcode 0x7F -> illegal=1, illegal_seen latches.
